// File: rtl/sync_fifo_mq_cnt_if.sv
// Handshake/data bundle between the queue user (master) and the multi-queue FIFO (slave).
interface sync_fifo_mq_cnt_if #(
    parameter int a_hi_size    = 4,
    parameter int a_lo_size    = 4,
    parameter int nr_of_queues = 16,
    parameter int data_width   = 36
);
    logic [data_width-1:0]                  d;
    logic [a_hi_size-1:0]                   wq;
    logic                                   write;
    logic [a_hi_size-1:0]                   rq;
    logic                                   read;
    logic [nr_of_queues-1:0]                flush;
    logic                                   err_clr;
    logic [data_width-1:0]                  q;
    logic                                   q_valid;
    logic [nr_of_queues-1:0]                fifo_full;
    logic [nr_of_queues-1:0]                fifo_almost_full;
    logic [nr_of_queues-1:0]                fifo_empty;
    logic [nr_of_queues*(a_lo_size+1)-1:0]  fill_level;
    logic [nr_of_queues-1:0]                overflow;
    logic [nr_of_queues-1:0]                underflow;

    modport master (
        output d, wq, write, rq, read, flush, err_clr,
        input  q, q_valid, fifo_full, fifo_almost_full, fifo_empty, fill_level, overflow, underflow
    );
    modport slave (
        input  d, wq, write, rq, read, flush, err_clr,
        output q, q_valid, fifo_full, fifo_almost_full, fifo_empty, fill_level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mq_cnt.sv
// Single-clock multi-queue FIFO: per-queue pointer/fill/error state in one lane instance per queue,
// all queues sharing one register-array RAM addressed as {queue, ptr}.
module sync_fifo_mq_cnt_q #(
    parameter int a_lo_size         = 4,
    parameter int almost_full_level = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_hit,
    input  logic                 rd_hit,
    input  logic                 err_clr,
    output logic [a_lo_size-1:0] wptr,
    output logic [a_lo_size-1:0] rptr,
    output logic [a_lo_size:0]   fill,
    output logic                 full,
    output logic                 almost_full,
    output logic                 empty,
    output logic                 wr_acc,
    output logic                 rd_acc,
    output logic                 overflow,
    output logic                 underflow
);
    localparam logic [a_lo_size:0] DEPTH = (a_lo_size+1)'(2**a_lo_size);
    localparam logic [a_lo_size:0] AF    = (a_lo_size+1)'(almost_full_level);

    assign full        = (fill == DEPTH);
    assign empty       = (fill == '0);
    assign almost_full = (fill >= AF);
    // flush masks both the access and its error report
    assign wr_acc      = wr_hit & ~full  & ~flush;
    assign rd_acc      = rd_hit & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            fill      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_hit & full  & ~flush) | (overflow  & ~err_clr);
            underflow <= (rd_hit & empty & ~flush) | (underflow & ~err_clr);
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
                fill <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + a_lo_size'(1);
                if (rd_acc) rptr <= rptr + a_lo_size'(1);
                if (wr_acc && !rd_acc)      fill <= fill + (a_lo_size+1)'(1);
                else if (rd_acc && !wr_acc) fill <= fill - (a_lo_size+1)'(1);
            end
        end
    end
endmodule

module sync_fifo_mq_cnt #(
    parameter int a_hi_size         = 4,
    parameter int a_lo_size         = 4,
    parameter int nr_of_queues      = 16,
    parameter int data_width        = 36,
    parameter int almost_full_level = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    sync_fifo_mq_cnt_if.slave    bus
);
    localparam int DEPTH = 2**a_lo_size;

    logic [data_width-1:0]                        ram [nr_of_queues*DEPTH];
    logic [nr_of_queues-1:0][a_lo_size-1:0]       wptr, rptr;
    logic [nr_of_queues-1:0][a_lo_size:0]         fill;
    logic [nr_of_queues-1:0] wr_hit, rd_hit, wr_acc, rd_acc;
    logic [nr_of_queues-1:0] full, almost_full, empty, overflow, underflow;
    logic [a_lo_size-1:0]    wptr_sel, rptr_sel;
    logic                    wr_any, rd_any;

    for (genvar i = 0; i < nr_of_queues; i++) begin : g_q
        // an index >= nr_of_queues matches no lane, so the strobe is ignored
        assign wr_hit[i] = bus.write && (bus.wq == a_hi_size'(i));
        assign rd_hit[i] = bus.read  && (bus.rq == a_hi_size'(i));

        sync_fifo_mq_cnt_q #(
            .a_lo_size(a_lo_size), .almost_full_level(almost_full_level)
        ) u_q (
            .clk(clk), .rst(rst), .flush(bus.flush[i]),
            .wr_hit(wr_hit[i]), .rd_hit(rd_hit[i]), .err_clr(bus.err_clr),
            .wptr(wptr[i]), .rptr(rptr[i]), .fill(fill[i]),
            .full(full[i]), .almost_full(almost_full[i]), .empty(empty[i]),
            .wr_acc(wr_acc[i]), .rd_acc(rd_acc[i]),
            .overflow(overflow[i]), .underflow(underflow[i])
        );
    end

    always_comb begin
        wptr_sel = '0;
        rptr_sel = '0;
        for (int i = 0; i < nr_of_queues; i++) begin
            if (wr_hit[i]) wptr_sel = wptr[i];
            if (rd_hit[i]) rptr_sel = rptr[i];
        end
    end

    assign wr_any = |wr_acc;
    assign rd_any = |rd_acc;

    always_ff @(posedge clk) begin
        if (wr_any) ram[{bus.wq, wptr_sel}] <= bus.d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.q       <= '0;
            bus.q_valid <= 1'b0;
        end else begin
            bus.q_valid <= rd_any;
            if (rd_any) bus.q <= ram[{bus.rq, rptr_sel}];
        end
    end

    assign bus.fifo_full        = full;
    assign bus.fifo_almost_full = almost_full;
    assign bus.fifo_empty       = empty;
    assign bus.fill_level       = fill;
    assign bus.overflow         = overflow;
    assign bus.underflow        = underflow;
endmodule

// File: tb/tb_sync_fifo_mq_cnt.sv
// Bench for sync_fifo_mq_cnt: queue model + read-data scoreboard, a corner-case vector table,
// and hand sequences for fill/drain, wrap/flush and mid-burst reset.
module tb_sync_fifo_mq_cnt;
    localparam int NQ = 16, AH = 4, AL = 4, DW = 36, AFL = 12, FW = AL + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_mq_cnt_if #(.a_hi_size(AH), .a_lo_size(AL), .nr_of_queues(NQ), .data_width(DW)) bus();

    sync_fifo_mq_cnt #(
        .a_hi_size(AH), .a_lo_size(AL), .nr_of_queues(NQ),
        .data_width(DW), .almost_full_level(AFL)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit              wr;  int wq; logic [DW-1:0] d;
        bit              rd;  int rq; logic [NQ-1:0] fl; bit ec;
        int              cq;  bit eqv; logic [DW-1:0] eq; int efill; bit eov; bit eun;
    } vec_t;

    int            n_vec = 0, n_err = 0;
    logic [DW-1:0] mdata [NQ][$];
    logic [DW-1:0] sb [$];
    logic [NQ-1:0] mov = '0, mun = '0;
    logic [DW-1:0] last_q = '0;
    vec_t          tv [10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all();
        logic [NQ*FW-1:0] ef;
        logic [NQ-1:0]    efull, eaf, eemp;
        for (int i = 0; i < NQ; i++) begin
            ef[i*FW +: FW] = FW'(mdata[i].size());
            efull[i] = (mdata[i].size() == 2**AL);
            eaf[i]   = (mdata[i].size() >= AFL);
            eemp[i]  = (mdata[i].size() == 0);
        end
        chk("fill_level", bus.fill_level, ef);
        chk("fifo_full", bus.fifo_full, efull);
        chk("fifo_almost_full", bus.fifo_almost_full, eaf);
        chk("fifo_empty", bus.fifo_empty, eemp);
        chk("overflow", bus.overflow, mov);
        chk("underflow", bus.underflow, mun);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NQ; i++) mdata[i].delete();
        sb.delete();
        mov = '0; mun = '0; last_q = '0;
    endtask

    // drive one cycle, update the model, then check one cycle later
    task automatic step(input bit wr, input int wqi, input logic [DW-1:0] dd,
                        input bit rd, input int rqi, input logic [NQ-1:0] fl, input bit ec);
        bit wf, re, wacc, racc;
        bus.write = wr; bus.wq = AH'(wqi); bus.d = dd;
        bus.read = rd;  bus.rq = AH'(rqi); bus.flush = fl; bus.err_clr = ec;
        wf   = (mdata[wqi].size() == 2**AL);
        re   = (mdata[rqi].size() == 0);
        wacc = wr && !wf && !fl[wqi];
        racc = rd && !re && !fl[rqi];
        if (ec) begin mov = '0; mun = '0; end
        if (wr && wf && !fl[wqi]) mov[wqi] = 1'b1;
        if (rd && re && !fl[rqi]) mun[rqi] = 1'b1;
        if (racc) sb.push_back(mdata[rqi].pop_front());
        if (wacc) mdata[wqi].push_back(dd);
        for (int i = 0; i < NQ; i++) if (fl[i]) mdata[i].delete();
        @(posedge clk); #1;
        chk("q_valid", bus.q_valid, racc);
        if (racc) begin
            if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
            else begin
                last_q = sb.pop_front();
                chk("q", bus.q, last_q);
            end
        end else chk("q_hold", bus.q, last_q);
        chk_all();
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, '0, 0);
    endtask

    initial begin
        bus.d = '0; bus.wq = '0; bus.write = 0; bus.rq = '0; bus.read = 0;
        bus.flush = '0; bus.err_clr = 0;
        tv[0] = '{1, 5, 36'h5FF, 1, 5, 16'h0000, 0, 5, 1, 36'h500, 15, 1, 0};
        tv[1] = '{0, 0, 36'h0,   0, 0, 16'h0000, 1, 5, 0, 36'h0,   15, 0, 0};
        tv[2] = '{1, 7, 36'hABC, 1, 7, 16'h0000, 0, 7, 0, 36'h0,    1, 0, 1};
        tv[3] = '{0, 0, 36'h0,   1, 7, 16'h0000, 0, 7, 1, 36'hABC,  0, 0, 1};
        tv[4] = '{0, 0, 36'h0,   0, 0, 16'h0000, 1, 7, 0, 36'h0,    0, 0, 0};
        tv[5] = '{0, 0, 36'h0,   1, 7, 16'h0080, 0, 7, 0, 36'h0,    0, 0, 0};
        tv[6] = '{1, 7, 36'h777, 0, 0, 16'h0080, 0, 7, 0, 36'h0,    0, 0, 0};
        tv[7] = '{1, 7, 36'h777, 0, 0, 16'h0000, 0, 7, 0, 36'h0,    1, 0, 0};
        tv[8] = '{0, 0, 36'h0,   1, 6, 16'h0000, 1, 6, 0, 36'h0,    0, 0, 1};
        tv[9] = '{0, 0, 36'h0,   1, 7, 16'h0080, 0, 7, 0, 36'h0,    0, 0, 0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", bus.q, 0);
        chk("rst_q_valid", bus.q_valid, 0);
        chk_all();
        rst = 1'b1;

        // fill queue 3; almost_full from the 12th write, full at 16
        for (int k = 1; k <= 16; k++) begin
            step(1, 3, DW'(k), 0, 0, '0, 0);
            if (k == 11) chk("af3_before", bus.fifo_almost_full[3], 0);
            if (k == 12) chk("af3_at12", bus.fifo_almost_full[3], 1);
        end
        chk("fill3_full", bus.fill_level[3*FW +: FW], 16);
        chk("full3", bus.fifo_full[3], 1);

        // drain queue 3 back-to-back
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, '0, 1, 3, '0, 0);
            chk("drain3_q", bus.q, DW'(k));
        end
        chk("empty3", bus.fifo_empty[3], 1);

        // fill queue 5, then the corner-case table
        for (int k = 0; k < 16; k++) step(1, 5, DW'(36'h500 + k), 0, 0, '0, 0);
        for (int v = 0; v < 10; v++) begin
            step(tv[v].wr, tv[v].wq, tv[v].d, tv[v].rd, tv[v].rq, tv[v].fl, tv[v].ec);
            chk($sformatf("tv%0d_qv", v), bus.q_valid, tv[v].eqv);
            if (tv[v].eqv) chk($sformatf("tv%0d_q", v), bus.q, tv[v].eq);
            chk($sformatf("tv%0d_fill", v), bus.fill_level[tv[v].cq*FW +: FW], FW'(tv[v].efill));
            chk($sformatf("tv%0d_ovf", v), bus.overflow[tv[v].cq], tv[v].eov);
            chk($sformatf("tv%0d_unf", v), bus.underflow[tv[v].cq], tv[v].eun);
        end

        // pointer wrap on queue 15, interleaved with queue 0, then flush queue 0
        for (int k = 0; k < 12; k++) step(1, 15, DW'(36'hE00 + k), 0, 0, '0, 0);
        for (int k = 0; k < 12; k++) step(0, 0, '0, 1, 15, '0, 0);
        for (int k = 0; k < 20; k++) step(1, (k % 2) ? 15 : 0, DW'(36'hF00 + k), 0, 0, '0, 0);
        step(0, 0, '0, 0, 0, 16'h0001, 0);
        chk("flush0_fill", bus.fill_level[0 +: FW], 0);
        chk("flush0_empty", bus.fifo_empty[0], 1);
        for (int j = 0; j < 10; j++) begin
            step(0, 0, '0, 1, 15, '0, 0);
            chk("wrap15_q", bus.q, DW'(36'hF01 + 2*j));
        end

        // reset mid-burst while reading queue 5
        step(0, 0, '0, 1, 5, '0, 0);
        step(0, 0, '0, 1, 5, '0, 0);
        bus.read = 1; bus.rq = AH'(5);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_q", bus.q, 0);
        chk("arst_q_valid", bus.q_valid, 0);
        chk_all();
        bus.read = 0;
        @(posedge clk); #1 rst = 1'b1;
        idle();
        step(0, 0, '0, 1, 5, '0, 0);
        chk("post_rst_unf5", bus.underflow[5], 1);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
